// File: rtl/iter_div.sv
// rtl/iter_div.sv - multi-cycle radix-2 restoring divider, signed/unsigned, with cancel
module iter_div #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cancel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_q,
   output logic [WIDTH-1:0] out_r,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] a_orig;
   logic             sign_q;
   logic             sign_r;
   logic             dz;

   logic [WIDTH-1:0] abs_a_in;
   logic [WIDTH-1:0] abs_b_in;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             last_step;

   // Magnitudes; the negation of MIN wraps to MIN, which read unsigned is 2^(WIDTH-1)
   assign abs_a_in  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
   assign abs_b_in  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

   // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract
   assign shifted   = {rem, quo[WIDTH-1]};
   assign trial     = shifted - {1'b0, abs_b};
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // Sign fix-up; divide-by-zero returns all ones and the untouched dividend
   assign q_fix     = dz ? {WIDTH{1'b1}} : (sign_q ? -quo : quo);
   assign r_fix     = dz ? a_orig : (sign_r ? -rem : rem);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; cancel overrides every transition
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (cancel) begin
         state_nxt = IDLE;
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         abs_b  <= '0;
         a_orig <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         dz     <= 1'b0;
         out_q  <= '0;
         out_r  <= '0;
      end else if (cancel) begin
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cnt    <= '0;
                  rem    <= '0;
                  quo    <= abs_a_in;
                  abs_b  <= abs_b_in;
                  a_orig <= in_a;
                  sign_q <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                  sign_r <= in_signed & in_a[WIDTH-1];
                  dz     <= (in_b == '0);
               end
            end
            CALC: begin
               cnt <= cnt + CNT_W'(1);
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               cnt   <= '0;
               out_q <= q_fix;
               out_r <= r_fix;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
